// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one RAM among NUM_REQ requesters, one command per transaction
module ram_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          busy,
   output logic [15:0]                   ram_opcode,
   output logic [15:0]                   ram_operand,
   output logic [15:0]                   ram_write_data,
   output logic                          ram_read_enable,
   output logic                          ram_write_enable,
   input  logic [15:0]                   ram_read_data
);
   localparam int IW = NUM_REQ > 2 ? 2 : 1;
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2;
   logic [1:0]            state;
   logic [IW-1:0]         rr_ptr, cmd_id, win_id;
   logic [IW-1:0]         cand [NUM_REQ];
   logic                  cmd_we, win_ok, issue;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   assign issue = state == ISSUE;
   always_comb begin
      for (int j = 0; j < NUM_REQ; j++) cand[j] = IW'((int'(rr_ptr) + j) % NUM_REQ);
   end
   // scanned from lowest priority up so the highest-priority hit is written last
   always_comb begin
      win_ok = 1'b0;
      win_id = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req[cand[j]]) begin
            win_ok = 1'b1;
            win_id = cand[j];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cmd_id    <= '0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         rdata     <= '0;
      end else begin
         if (issue && !cmd_we) rdata <= DATA_WIDTH'(ram_read_data);
         if (!issue && win_ok) begin
            state     <= ISSUE;
            rr_ptr    <= IW'((int'(win_id) + 1) % NUM_REQ);
            cmd_id    <= win_id;
            cmd_we    <= req_we[win_id];
            cmd_addr  <= req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];
            cmd_wdata <= req_wdata[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            state <= issue ? RESP : IDLE;
         end
      end
   end
   assign gnt              = issue ? NUM_REQ'(1) << cmd_id : '0;
   assign done             = state == RESP ? NUM_REQ'(1) << cmd_id : '0;
   assign busy             = state != IDLE;
   assign ram_opcode       = !issue ? 16'h0000 : cmd_we ? 16'h9100 : 16'h9200;
   assign ram_operand      = issue ? 16'(cmd_addr) : '0;
   assign ram_write_data   = issue && cmd_we ? 16'(cmd_wdata) : '0;
   assign ram_read_enable  = issue && !cmd_we;
   assign ram_write_enable = issue && cmd_we;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors against a behavioural 256x16 RAM
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  req = '0, req_we = '0;
   logic [23:0] req_addr = '0;
   logic [47:0] req_wdata = '0;
   logic [2:0]  gnt, done;
   logic [15:0] rdata, ram_opcode, ram_operand, ram_write_data, ram_read_data;
   logic        busy, ram_read_enable, ram_write_enable;
   logic [15:0] mem [256];
   int          vec = 0, errs = 0, wcnt = 0;

   ram_arbiter #(.NUM_REQ(3), .DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .ram_opcode(ram_opcode), .ram_operand(ram_operand), .ram_write_data(ram_write_data),
      .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
      .ram_read_data(ram_read_data)
   );

   always #5 clk = ~clk;
   assign ram_read_data = ram_read_enable ? mem[ram_operand[7:0]] : 16'h0000;
   always @(posedge clk) begin
      if (ram_write_enable) begin
         mem[ram_operand[7:0]] <= ram_write_data;
         wcnt <= wcnt + 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic ram_quiet(input string tag);
      chk({tag, "_opcode"}, ram_opcode, 0);
      chk({tag, "_operand"}, ram_operand, 0);
      chk({tag, "_wdata"}, ram_write_data, 0);
      chk({tag, "_re"}, ram_read_enable, 0);
      chk({tag, "_we"}, ram_write_enable, 0);
   endtask

   task automatic set_req(input int id, input bit we, input logic [7:0] a, input logic [15:0] wd);
      req[id] = 1'b1;
      req_we[id] = we;
      req_addr[id*8 +: 8] = a;
      req_wdata[id*16 +: 16] = wd;
   endtask

   task automatic txn(input int id, input bit we, input logic [7:0] a, input logic [15:0] wd,
                      input logic [15:0] exp_rd);
      set_req(id, we, a, wd);
      tick;
      chk("txn_gnt", gnt, 32'(1 << id));
      chk("txn_busy", busy, 1);
      chk("txn_opcode", ram_opcode, we ? 16'h9100 : 16'h9200);
      chk("txn_operand", ram_operand, {8'h00, a});
      chk("txn_wdata", ram_write_data, we ? wd : 16'h0000);
      chk("txn_we", ram_write_enable, we);
      chk("txn_re", ram_read_enable, !we);
      req[id] = 1'b0;
      tick;
      chk("txn_done", done, 32'(1 << id));
      chk("txn_gnt_resp", gnt, 0);
      chk("txn_rdata", rdata, exp_rd);
      ram_quiet("resp");
      tick;
      chk("txn_idle_busy", busy, 0);
      chk("txn_idle_done", done, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      tick;
      tick;
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      ram_quiet("rst");
      reset = 1'b1;
      tick;
      txn(2, 1, 8'h05, 16'hBEEF, 16'h0000);
      txn(0, 0, 8'h05, 16'h0000, 16'hBEEF);

      reset = 1'b0;
      tick;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) set_req(i, 0, 8'h00, 16'h0000);
      for (int c = 0; c < 12; c++) begin
         tick;
         chk("rr_gnt", gnt, c % 2 == 0 ? 32'(1 << ((c / 2) % 3)) : 0);
         chk("rr_done", done, c % 2 == 1 ? 32'(1 << ((c / 2) % 3)) : 0);
         chk("rr_busy", busy, 1);
         if (c == 10) req = '0;
      end
      tick;
      chk("rr_end_busy", busy, 0);

      set_req(1, 0, 8'h00, 16'h0000);
      tick;
      chk("rot_gnt1", gnt, 3'b010);
      set_req(0, 0, 8'h00, 16'h0000);
      tick;
      chk("rot_done1", done, 3'b010);
      tick;
      chk("rot_gnt0", gnt, 3'b001);
      req = 3'b010;
      tick;
      chk("rot_done0", done, 3'b001);
      tick;
      chk("rot_gnt1b", gnt, 3'b010);
      req = '0;
      tick;
      tick;
      chk("rot_idle", busy, 0);

      txn(0, 1, 8'h10, 16'h1234, 16'h0000);
      txn(1, 0, 8'h10, 16'h0000, 16'h1234);
      txn(2, 1, 8'h10, 16'h5678, 16'h1234);
      chk("hold_mem", mem[8'h10], 16'h5678);

      for (int c = 0; c < 5; c++) begin
         tick;
         ram_quiet("idle");
         chk("idle_busy", busy, 0);
      end
      chk("idle_wcnt", wcnt, 3);

      set_req(1, 1, 8'h20, 16'hAAAA);
      tick;
      chk("rstmid_gnt", gnt, 3'b010);
      reset = 1'b0;
      req = '0;
      tick;
      chk("rstmid_done", done, 0);
      chk("rstmid_gnt0", gnt, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_rdata", rdata, 0);
      ram_quiet("rstmid");
      reset = 1'b1;
      tick;
      chk("rstmid_done2", done, 0);
      chk("rstmid_mem", mem[8'h20], 16'hAAAA);
      set_req(0, 0, 8'h20, 16'h0000);
      set_req(2, 0, 8'h00, 16'h0000);
      tick;
      chk("ptr0_gnt", gnt, 3'b001);
      req = 3'b100;
      tick;
      chk("ptr0_done", done, 3'b001);
      chk("ptr0_rdata", rdata, 16'hAAAA);
      tick;
      chk("ptr0_gnt2", gnt, 3'b100);
      req = '0;
      tick;
      chk("ptr0_done2", done, 3'b100);
      tick;
      chk("end_busy", busy, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
